// File: rtl/pipe_hazard_if.sv
// Bundle between the pipeline datapath and the hazard controller: decode/EX
// fields toward the controller, latch qualifiers and stall count back.
interface pipe_hazard_if #(
  parameter int CNT_W = 16
);
  logic [31:0]      id_instruc;
  logic [31:0]      ex_instruc;
  logic             ex_mem_read;
  logic             ex_muldiv;
  logic             branch_taken;
  logic             pc_en;
  logic             if_id_en;
  logic             id_ex_en;
  logic             id_ex_bubble;
  logic             if_id_flush;
  logic             ex_mem_bubble;
  logic [CNT_W-1:0] stall_cycles;
  logic             fsm_busy;

  // Handshake: no valid/ready. Every field is sampled each cycle. The
  // qualifiers are a same-cycle function of the fields and the controller
  // state, and they act on the latches at the next rising clock edge.
  modport master (
    output id_instruc, ex_instruc, ex_mem_read, ex_muldiv, branch_taken,
    input  pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush,
           ex_mem_bubble, stall_cycles, fsm_busy
  );

  modport slave (
    input  id_instruc, ex_instruc, ex_mem_read, ex_muldiv, branch_taken,
    output pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush,
           ex_mem_bubble, stall_cycles, fsm_busy
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall controller for the 5-stage core: load-use stalls, taken-branch
// flushes, mul/div EX occupancy, and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
  parameter int MULDIV_LAT = 4,
  parameter int CNT_W      = 16
) (
  input logic         clk,
  input logic         reset,
  pipe_hazard_if.slave hz
);

  typedef enum logic {RUN, BUSY} state_t;

  localparam logic [7:0] FREEZE_CNT = 8'(MULDIV_LAT - 1);

  state_t           state, state_next;
  logic [7:0]       cnt, cnt_next;
  logic [CNT_W-1:0] stall_q;

  logic pc_en_c, if_id_en_c, id_ex_en_c;
  logic id_ex_bubble_c, if_id_flush_c, ex_mem_bubble_c;

  logic [4:0] id_rs, id_rt, ex_rt;
  logic       load_use;

  assign id_rs = hz.id_instruc[25:21];
  assign id_rt = hz.id_instruc[20:16];
  assign ex_rt = hz.ex_instruc[20:16];

  // Register 0 is hardwired zero, so a load targeting it never stalls.
  assign load_use = hz.ex_mem_read && (ex_rt != 5'd0) &&
                    ((ex_rt == id_rs) || (ex_rt == id_rt));

  wire unused_instr_bits = ^{hz.id_instruc[31:26], hz.id_instruc[15:0],
                             hz.ex_instruc[31:21], hz.ex_instruc[15:0]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      cnt     <= 8'd0;
      stall_q <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
      if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + 1'b1;
      end
    end
  end

  always_comb begin
    state_next      = state;
    cnt_next        = cnt;
    pc_en_c         = 1'b0;
    if_id_en_c      = 1'b0;
    id_ex_en_c      = 1'b0;
    id_ex_bubble_c  = 1'b0;
    if_id_flush_c   = 1'b0;
    ex_mem_bubble_c = 1'b0;
    // Outputs are gated by reset so everything reads zero while it is held.
    if (reset) begin
      case (state)
        RUN: begin
          if (hz.ex_muldiv) begin
            ex_mem_bubble_c = 1'b1;
            cnt_next        = FREEZE_CNT;
            state_next      = BUSY;
          end else if (hz.branch_taken) begin
            pc_en_c        = 1'b1;
            if_id_en_c     = 1'b1;
            id_ex_en_c     = 1'b1;
            if_id_flush_c  = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else if (load_use) begin
            id_ex_en_c     = 1'b1;
            id_ex_bubble_c = 1'b1;
          end else begin
            pc_en_c    = 1'b1;
            if_id_en_c = 1'b1;
            id_ex_en_c = 1'b1;
          end
        end
        BUSY: begin
          if (cnt > 8'd1) begin
            ex_mem_bubble_c = 1'b1;
            cnt_next        = cnt - 8'd1;
          end else begin
            pc_en_c    = 1'b1;
            if_id_en_c = 1'b1;
            id_ex_en_c = 1'b1;
            cnt_next   = 8'd0;
            state_next = RUN;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  assign hz.pc_en         = pc_en_c;
  assign hz.if_id_en      = if_id_en_c;
  assign hz.id_ex_en      = id_ex_en_c;
  assign hz.id_ex_bubble  = id_ex_bubble_c;
  assign hz.if_id_flush   = if_id_flush_c;
  assign hz.ex_mem_bubble = ex_mem_bubble_c;
  assign hz.stall_cycles  = stall_q;
  assign hz.fsm_busy      = (state == BUSY);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a CNT_W=16 instance for function and a
// CNT_W=4 instance sharing the same inputs for counter saturation.
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] id_instruc, ex_instruc;
  logic        ex_mem_read, ex_muldiv, branch_taken;

  pipe_hazard_if #(.CNT_W(16)) hz ();
  pipe_hazard_if #(.CNT_W(4))  hz_s ();

  assign hz.id_instruc     = id_instruc;
  assign hz.ex_instruc     = ex_instruc;
  assign hz.ex_mem_read    = ex_mem_read;
  assign hz.ex_muldiv      = ex_muldiv;
  assign hz.branch_taken   = branch_taken;
  assign hz_s.id_instruc   = id_instruc;
  assign hz_s.ex_instruc   = ex_instruc;
  assign hz_s.ex_mem_read  = ex_mem_read;
  assign hz_s.ex_muldiv    = ex_muldiv;
  assign hz_s.branch_taken = branch_taken;

  pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .hz(hz.slave)
  );
  pipe_hazard_ctrl #(.MULDIV_LAT(4), .CNT_W(4)) dut_s (
    .clk(clk), .reset(reset), .hz(hz_s.slave)
  );

  // {pc_en, if_id_en, id_ex_en, id_ex_bubble, if_id_flush, ex_mem_bubble}
  wire [5:0] outs = {hz.pc_en, hz.if_id_en, hz.id_ex_en,
                     hz.id_ex_bubble, hz.if_id_flush, hz.ex_mem_bubble};

  localparam logic [5:0] O_ZERO   = 6'b000000;
  localparam logic [5:0] O_RUN    = 6'b111000;
  localparam logic [5:0] O_LDUSE  = 6'b001100;
  localparam logic [5:0] O_FREEZE = 6'b000001;
  localparam logic [5:0] O_FLUSH  = 6'b111110;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_stall = 16'd0;

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [4:0] id_rs, input logic [4:0] id_rt,
                        input logic [4:0] ex_rt, input logic mr,
                        input logic md, input logic bt);
    id_instruc   = {6'h00, id_rs, id_rt, 16'h0020};
    ex_instruc   = {6'h23, 5'd2, ex_rt, 16'h0004};
    ex_mem_read  = mr;
    ex_muldiv    = md;
    branch_taken = bt;
  endtask

  task automatic set_idle();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    set_idle();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== O_ZERO) begin
        n_fail++; $display("FAIL reset_outs cyc=%0d got=%b exp=%b", i, outs, O_ZERO);
      end
      n_checks++;
      if (hz.stall_cycles !== 16'd0) begin
        n_fail++; $display("FAIL reset_stall got=%0d exp=0", hz.stall_cycles);
      end
    end
    next_cyc();
    reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL release_outs got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (hz.fsm_busy !== 1'b0) begin
      n_fail++; $display("FAIL release_state got=%b exp=0", hz.fsm_busy);
    end
    exp_stall = 16'd0;
    next_cyc();
  endtask

  task automatic test_load_use();
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_LDUSE) begin
      n_fail++; $display("FAIL lduse_rs got=%b exp=%b", outs, O_LDUSE);
    end
    next_cyc();
    exp_stall = exp_stall + 16'd1;
    set_in(5'd8, 5'd3, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL lduse_after got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (hz.stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL lduse_stall got=%0d exp=%0d", hz.stall_cycles, exp_stall);
    end
    next_cyc();
    set_in(5'd3, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_LDUSE) begin
      n_fail++; $display("FAIL lduse_rt got=%b exp=%b", outs, O_LDUSE);
    end
    next_cyc();
    exp_stall = exp_stall + 16'd1;
    set_in(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL lduse_r0 got=%b exp=%b", outs, O_RUN);
    end
    next_cyc();
    set_in(5'd8, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL lduse_nomatch got=%b exp=%b", outs, O_RUN);
    end
    next_cyc();
    set_in(5'd8, 5'd3, 5'd8, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL lduse_noread got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (hz.stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL lduse_stall2 got=%0d exp=%0d", hz.stall_cycles, exp_stall);
    end
    next_cyc();
  endtask

  task automatic test_muldiv();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_FREEZE || hz.fsm_busy !== 1'b0) begin
      n_fail++; $display("FAIL muldiv_T got=%b busy=%b exp=%b busy=0", outs, hz.fsm_busy, O_FREEZE);
    end
    for (int k = 1; k <= 2; k++) begin
      next_cyc();
      // Load-use match, branch and a fresh mul/div must all be ignored.
      set_in(5'd8, 5'd8, 5'd8, 1'b1, k[0], 1'b1);
      @(negedge clk);
      n_checks++;
      if (outs !== O_FREEZE || hz.fsm_busy !== 1'b1) begin
        n_fail++; $display("FAIL muldiv_T+%0d got=%b busy=%b exp=%b busy=1", k, outs, hz.fsm_busy, O_FREEZE);
      end
    end
    next_cyc();
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL muldiv_release got=%b exp=%b", outs, O_RUN);
    end
    next_cyc();
    set_idle();
    exp_stall = exp_stall + 16'd3;
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN || hz.fsm_busy !== 1'b0) begin
      n_fail++; $display("FAIL muldiv_after got=%b busy=%b exp=%b busy=0", outs, hz.fsm_busy, O_RUN);
    end
    n_checks++;
    if (hz.stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL muldiv_stall got=%0d exp=%0d", hz.stall_cycles, exp_stall);
    end
    next_cyc();
  endtask

  task automatic test_back_to_back_branch();
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (outs !== O_FLUSH) begin
      n_fail++; $display("FAIL branch_lduse got=%b exp=%b", outs, O_FLUSH);
    end
    next_cyc();
    set_in(5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    n_checks++;
    if (outs !== O_FLUSH) begin
      n_fail++; $display("FAIL branch_b2b got=%b exp=%b", outs, O_FLUSH);
    end
    next_cyc();
    set_idle();
    @(negedge clk);
    n_checks++;
    if (outs !== O_RUN) begin
      n_fail++; $display("FAIL branch_after got=%b exp=%b", outs, O_RUN);
    end
    n_checks++;
    if (hz.stall_cycles !== exp_stall) begin
      n_fail++; $display("FAIL branch_stall got=%0d exp=%0d", hz.stall_cycles, exp_stall);
    end
    next_cyc();
  endtask

  task automatic test_reset_mid_busy();
    set_in(5'd1, 5'd2, 5'd3, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    n_checks++;
    if (outs !== O_FREEZE) begin
      n_fail++; $display("FAIL rstbusy_T got=%b exp=%b", outs, O_FREEZE);
    end
    next_cyc();
    set_idle();
    reset = 1'b0;
    #1;
    n_checks++;
    if (outs !== O_ZERO || hz.fsm_busy !== 1'b0) begin
      n_fail++; $display("FAIL rstbusy_outs got=%b busy=%b exp=%b busy=0", outs, hz.fsm_busy, O_ZERO);
    end
    n_checks++;
    if (hz.stall_cycles !== 16'd0) begin
      n_fail++; $display("FAIL rstbusy_stall got=%0d exp=0", hz.stall_cycles);
    end
    next_cyc();
    reset = 1'b1;
    exp_stall = 16'd0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (outs !== O_RUN || hz.fsm_busy !== 1'b0) begin
        n_fail++; $display("FAIL rstbusy_resume%0d got=%b busy=%b exp=%b busy=0", k, outs, hz.fsm_busy, O_RUN);
      end
      next_cyc();
    end
    n_checks++;
    if (hz.stall_cycles !== 16'd0 || hz_s.stall_cycles !== 4'd0) begin
      n_fail++; $display("FAIL rstbusy_stall_after got=%0d/%0d exp=0/0", hz.stall_cycles, hz_s.stall_cycles);
    end
  endtask

  task automatic test_saturate();
    logic [3:0] e;
    set_in(5'd8, 5'd3, 5'd8, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      next_cyc();
      if (i == 14 || i == 15 || i == 20) begin
        e = (i >= 15) ? 4'd15 : 4'(i);
        n_checks++;
        if (hz_s.stall_cycles !== e) begin
          n_fail++; $display("FAIL sat_cnt i=%0d got=%0d exp=%0d", i, hz_s.stall_cycles, e);
        end
      end
    end
    n_checks++;
    if (hz.stall_cycles !== 16'd20) begin
      n_fail++; $display("FAIL sat_wide got=%0d exp=20", hz.stall_cycles);
    end
    set_idle();
    next_cyc();
    n_checks++;
    if (hz_s.stall_cycles !== 4'd15) begin
      n_fail++; $display("FAIL sat_hold got=%0d exp=15", hz_s.stall_cycles);
    end
  endtask

  initial begin
    set_idle();
    test_reset();
    test_load_use();
    test_muldiv();
    test_back_to_back_branch();
    test_reset_mid_busy();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
